// File: rtl/fg_pkg.sv
// Shared constants and helpers for the function generator output stage.
package fg_pkg;

  localparam int unsigned DEFAULT_WAVEFORM_BITWIDTH = 16;
  localparam int unsigned DEFAULT_PWM_BITWIDTH      = 8;
  localparam int unsigned PWM_FRAME_LEN             = 2 ** DEFAULT_PWM_BITWIDTH;

  // Number of clk_i cycles in one PWM frame for a P-bit modulator.
  function automatic int unsigned pwm_frame_len(input int unsigned p);
    return 32'd1 << p;
  endfunction

endpackage

// File: rtl/fg_output_stage_if.sv
// Sample-in / conditioned-code-out bundle of the output stage.
interface fg_output_stage_if
  import fg_pkg::*;
#(
  parameter int unsigned WAVEFORM_BITWIDTH = DEFAULT_WAVEFORM_BITWIDTH
);

  logic                         clk_en_i;
  logic                         en_i;
  logic                         invert_i;
  logic [WAVEFORM_BITWIDTH:0]   wave_i;
  logic [WAVEFORM_BITWIDTH:0]   offset_i;
  logic [WAVEFORM_BITWIDTH-1:0] dac_o;
  logic                         sat_o;
  logic                         pwm_o;
  logic                         frame_o;

  modport master (
    output clk_en_i, en_i, invert_i, wave_i, offset_i,
    input  dac_o, sat_o, pwm_o, frame_o
  );

  modport slave (
    input  clk_en_i, en_i, invert_i, wave_i, offset_i,
    output dac_o, sat_o, pwm_o, frame_o
  );

endinterface

// File: rtl/fg_pwm_modulator.sv
// First-order noise-shaped PWM: duty is requantised from the DAC code once per frame and
// the truncated LSBs carry over into the next frame.
module fg_pwm_modulator
  import fg_pkg::*;
#(
  parameter int unsigned WAVEFORM_BITWIDTH = DEFAULT_WAVEFORM_BITWIDTH,
  parameter int unsigned PWM_BITWIDTH      = DEFAULT_PWM_BITWIDTH
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         en_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] dac_i,
  output logic                         pwm_o,
  output logic                         frame_o
);

  localparam int unsigned W = WAVEFORM_BITWIDTH;
  localparam int unsigned P = PWM_BITWIDTH;
  localparam logic [P-1:0] CntLast = P'(pwm_frame_len(P) - 1);

  logic [P-1:0]   cnt_q, cnt_d;
  logic [P:0]     duty_q, duty_d;
  logic [W-P-1:0] err_q, err_d;
  logic           pwm_q, pwm_d;
  logic           frame_q, frame_d;
  logic [W:0]     acc;

  always_comb begin
    cnt_d   = '0;
    duty_d  = '0;
    err_d   = '0;
    pwm_d   = 1'b0;
    frame_d = 1'b0;
    acc     = {1'b0, dac_i} + {{(P + 1){1'b0}}, err_q};
    if (en_i) begin
      cnt_d   = cnt_q + 1'b1;
      duty_d  = duty_q;
      err_d   = err_q;
      // P+1 bit compare so that duty = 2^P keeps the pin high for the whole frame.
      pwm_d   = ({1'b0, cnt_q} < duty_q);
      frame_d = (cnt_q == '0);
      if (cnt_q == CntLast) begin
        duty_d = acc[W:W-P];
        err_d  = acc[W-P-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      err_q   <= '0;
      pwm_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      err_q   <= err_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign frame_o = frame_q;

endmodule

// File: rtl/fg_output_stage.sv
// Output stage: offset add, clip to unsigned DAC code, optional inversion, registered DAC
// port plus noise-shaped PWM.
module fg_output_stage
  import fg_pkg::*;
#(
  parameter int unsigned WAVEFORM_BITWIDTH = DEFAULT_WAVEFORM_BITWIDTH,
  parameter int unsigned PWM_BITWIDTH      = DEFAULT_PWM_BITWIDTH
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  fg_output_stage_if.slave bus
);

  localparam int unsigned W = WAVEFORM_BITWIDTH;

  logic [W+1:0] sum;
  logic         sum_neg;
  logic         sum_over;
  logic [W-1:0] clipped;
  logic [W-1:0] code;
  logic [W-1:0] dac_q, dac_d;
  logic         sat_q, sat_d;
  logic         pwm;
  logic         frame;

  always_comb begin
    // Sign-extend both operands to W+2 bits so the sum can never wrap.
    sum      = {bus.wave_i[W], bus.wave_i} + {bus.offset_i[W], bus.offset_i};
    sum_neg  = sum[W+1];
    sum_over = !sum[W+1] && sum[W];
    if (sum_neg) begin
      clipped = '0;
    end else if (sum_over) begin
      clipped = '1;
    end else begin
      clipped = sum[W-1:0];
    end
    code  = bus.invert_i ? ~clipped : clipped;
    dac_d = dac_q;
    sat_d = sat_q;
    if (bus.clk_en_i) begin
      dac_d = code;
      sat_d = sum_neg || sum_over;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dac_q <= '0;
      sat_q <= 1'b0;
    end else begin
      dac_q <= dac_d;
      sat_q <= sat_d;
    end
  end

  fg_pwm_modulator #(
    .WAVEFORM_BITWIDTH (WAVEFORM_BITWIDTH),
    .PWM_BITWIDTH      (PWM_BITWIDTH)
  ) u_pwm (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .en_i    (bus.en_i),
    .dac_i   (dac_q),
    .pwm_o   (pwm),
    .frame_o (frame)
  );

  assign bus.dac_o   = dac_q;
  assign bus.sat_o   = sat_q;
  assign bus.pwm_o   = pwm;
  assign bus.frame_o = frame;

endmodule

// File: tb/tb_fg_output_stage.sv
// Directed bench for fg_output_stage with W = 16, P = 8.
module tb_fg_output_stage;

  logic clk_i;
  logic rstn_i;
  int   total;
  int   bad;

  fg_output_stage_if #(.WAVEFORM_BITWIDTH(16)) bus ();

  fg_output_stage #(
    .WAVEFORM_BITWIDTH (16),
    .PWM_BITWIDTH      (8)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Starts on a frame_o cycle, counts pwm_o highs over 256 cycles, ends on the next cycle.
  task automatic frame_highs(output int highs, output int stray);
    highs = int'(bus.pwm_o);
    stray = 0;
    for (int i = 1; i < 256; i++) begin
      step();
      highs += int'(bus.pwm_o);
      if (bus.frame_o) stray++;
    end
    step();
  endtask

  task automatic set_wave(input int w, input int o);
    bus.wave_i   = 17'(w);
    bus.offset_i = 17'(o);
  endtask

  task automatic check_dac(input string name, input int exp_dac, input logic exp_sat);
    total++;
    if (bus.dac_o !== 16'(exp_dac)) begin
      bad++;
      $display("FAIL %s dac: got %0d want %0d", name, bus.dac_o, exp_dac);
    end
    total++;
    if (bus.sat_o !== exp_sat) begin
      bad++;
      $display("FAIL %s sat: got %0b want %0b", name, bus.sat_o, exp_sat);
    end
  endtask

  task automatic run_frames(input string name, input int n, input int exp_h[5]);
    int h;
    int s;
    for (int f = 0; f < n; f++) begin
      frame_highs(h, s);
      total++;
      if (h !== exp_h[f]) begin
        bad++;
        $display("FAIL %s frame%0d highs: got %0d want %0d", name, f, h, exp_h[f]);
      end
      total++;
      if (s !== 0) begin
        bad++;
        $display("FAIL %s frame%0d stray frame_o: got %0d want 0", name, f, s);
      end
      total++;
      if (bus.frame_o !== 1'b1) begin
        bad++;
        $display("FAIL %s frame%0d period: frame_o got %0b want 1", name, f, bus.frame_o);
      end
    end
  endtask

  task automatic start_pwm(input string name, input int w);
    bus.en_i = 1'b0;
    set_wave(w, 0);
    step();
    bus.en_i = 1'b1;
    step();
    total++;
    if (bus.frame_o !== 1'b1) begin
      bad++;
      $display("FAIL %s first frame_o: got %0b want 1", name, bus.frame_o);
    end
  endtask

  task automatic test_reset();
    rstn_i       = 1'b0;
    bus.clk_en_i = 1'b1;
    bus.en_i     = 1'b0;
    bus.invert_i = 1'b0;
    set_wave(1234, 0);
    #3;
    check_dac("reset", 0, 1'b0);
    total++;
    if ({bus.pwm_o, bus.frame_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset pwm/frame: got %b want 00", {bus.pwm_o, bus.frame_o});
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    step();
  endtask

  task automatic test_clip();
    bus.clk_en_i = 1'b1;
    bus.invert_i = 1'b0;
    set_wave(1000, -2000);
    step();
    check_dac("neg_clip", 0, 1'b1);
    bus.invert_i = 1'b1;
    step();
    check_dac("neg_clip_inv", 65535, 1'b1);
    bus.invert_i = 1'b0;
    set_wave(65535, 100);
    step();
    check_dac("pos_clip", 65535, 1'b1);
    set_wave(30000, -5000);
    step();
    check_dac("pass", 25000, 1'b0);
  endtask

  task automatic test_hold();
    bus.clk_en_i = 1'b0;
    set_wave(1, 0);
    step();
    check_dac("hold", 25000, 1'b0);
    bus.clk_en_i = 1'b1;
    bus.invert_i = 1'b1;
    set_wave(30000, -5000);
    step();
    check_dac("pass_inv", 40535, 1'b0);
    bus.invert_i = 1'b0;
  endtask

  task automatic test_half_duty();
    int exp_h[5] = '{0, 128, 128, 0, 0};
    start_pwm("half", 32768);
    run_frames("half", 3, exp_h);
  endtask

  task automatic test_noise_shaping();
    int exp_h[5] = '{0, 0, 1, 0, 1};
    start_pwm("noise", 128);
    run_frames("noise", 5, exp_h);
  endtask

  task automatic test_full_scale();
    int exp_h[5] = '{0, 255, 256, 0, 0};
    start_pwm("full", 65535);
    run_frames("full", 3, exp_h);
  endtask

  task automatic test_en_drop();
    int h;
    int s;
    start_pwm("en_drop", 32768);
    frame_highs(h, s);
    repeat (5) step();
    total++;
    if (bus.pwm_o !== 1'b1) begin
      bad++;
      $display("FAIL en_drop pwm before drop: got %0b want 1", bus.pwm_o);
    end
    bus.en_i = 1'b0;
    step();
    total++;
    if ({bus.pwm_o, bus.frame_o} !== 2'b00) begin
      bad++;
      $display("FAIL en_drop pwm/frame: got %b want 00", {bus.pwm_o, bus.frame_o});
    end
    bus.en_i = 1'b1;
    step();
    total++;
    if ({bus.pwm_o, bus.frame_o} !== 2'b01) begin
      bad++;
      $display("FAIL en_drop restart pwm/frame: got %b want 01", {bus.pwm_o, bus.frame_o});
    end
  endtask

  task automatic test_async_reset();
    int h;
    int s;
    frame_highs(h, s);
    repeat (3) step();
    total++;
    if (bus.pwm_o !== 1'b1) begin
      bad++;
      $display("FAIL async_rst pwm before reset: got %0b want 1", bus.pwm_o);
    end
    rstn_i = 1'b0;
    #2;
    check_dac("async_rst", 0, 1'b0);
    total++;
    if ({bus.pwm_o, bus.frame_o} !== 2'b00) begin
      bad++;
      $display("FAIL async_rst pwm/frame: got %b want 00", {bus.pwm_o, bus.frame_o});
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    step();
    check_dac("post_rst", 32768, 1'b0);
    total++;
    if ({bus.pwm_o, bus.frame_o} !== 2'b01) begin
      bad++;
      $display("FAIL post_rst pwm/frame: got %b want 01", {bus.pwm_o, bus.frame_o});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clip();
    test_hold();
    test_half_duty();
    test_noise_shaping();
    test_full_scale();
    test_en_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
